synch_fifo_core: RTL and testbench
==================================

// Module: synch_fifo_core
// PURPOSE
//  Single-clock synchronous FIFO, 8 x 16-bit, with registered read data.
//  Flags: registered full/empty, look-ahead full_nxt/empty_nxt, occupancy and free-space counts.
//  Debug tap exposes the head-of-queue word.
//  General-purpose buffering between producer/consumer logic in the same clock domain.
// PARAMETERS
//  DATA_W  16  data word width
//  DEPTH   8   number of entries (power of 2)
//  ADDR_W  3   pointer width, log2(DEPTH)
//  CNT_W   4   count width, log2(DEPTH)+1 (holds 0..DEPTH)
// PORTS
//  clk          in   1       rising-edge clock; single clock domain
//  reset        in   1       asynchronous, active-low reset (0 = in reset)
//  wr_en        in   1       write request; write_data sampled on clk edge
//  rd_en        in   1       read request
//  write_data   in   DATA_W  word to enqueue
//  read_data    out  DATA_W  registered dequeued word
//  full         out  1       registered; count == DEPTH
//  empty        out  1       registered; count == 0
//  full_nxt     out  1       combinational; value full takes at next edge
//  empty_nxt    out  1       combinational; value empty takes at next edge
//  room_avail   out  CNT_W   DEPTH - count (registered)
//  data_avail   out  CNT_W   count (registered)
//  memory_wire  out  DATA_W  combinational: mem[rd_ptr], the next word to be read
// BEHAVIOUR
//  - Reset (reset==0, async):
//    - wr_ptr=rd_ptr=0; count=0.
//    - empty=1, full=0; data_avail=0; room_avail=DEPTH.
//    - read_data=0; all storage cleared to 0, so memory_wire=0.
//    - Reset mid-operation discards all contents immediately.
//  - Accept rules, evaluated on pre-edge state:
//    - wr_acc = wr_en & ~full
//    - rd_acc = rd_en & ~empty
//  - Write: on posedge with wr_acc:
//    - mem[wr_ptr] <= write_data; wr_ptr increments mod DEPTH (natural wrap).
//  - Read: on posedge with rd_acc:
//    - read_data <= mem[rd_ptr]; rd_ptr increments mod DEPTH.
//    - Latency: data valid the cycle after the rd_en edge; held until the next accepted read.
//  - Overflow: wr_en while full is ignored; no pointer, count or data change; no error flag.
//  - Underflow: rd_en while empty is ignored; read_data holds its last value.
//  - Simultaneous wr_acc & rd_acc: count unchanged; both pointers advance.
//    - Full + rd & wr: only the read is accepted.
//    - Empty + rd & wr: only the write is accepted; no bypass.
//  - count_nxt = count + wr_acc - rd_acc; count, full, empty and avails register count_nxt values.
//  - full_nxt = (count_nxt==DEPTH); empty_nxt = (count_nxt==0).
//  - Invariant: data_avail + room_avail == DEPTH at all times.
// TESTING
//  - Reset: hold reset=0 for 100ns, release -> empty=1, full=0, data_avail=0, room_avail=8, read_data=0.
//  - Read-after-write x8: write random byte v (zero-extended), then pulse rd_en one cycle
//    -> read_data==v one cycle later; empty returns to 1.
//  - Fill: write ~(i+1) for i=0..8 -> full=1 and room_avail=0 after the 8th write;
//    9th write (0xF6) dropped; data_avail=8.
//  - Drain + underflow: 20 single reads -> 0xFE,0xFD,...,0xF7 in order.
//    After the 8th read empty=1; reads 9-20 keep read_data=0xF7.
//  - Simultaneous: with 3 entries, assert wr_en & rd_en one cycle -> data_avail stays 3, oldest word out.
//    When full, assert both -> read only, count 7; when empty, assert both -> write only, count 1.
//  - Wrap/reset: 20 write/read pairs (pointers wrap) keep data order;
//    assert reset with 5 entries held -> empty=1, count 0 immediately, without a clock edge.

Source files
------------

// File: rtl/synch_fifo_core.sv
// synch_fifo_core: single-clock 8x16 FIFO with registered read data, look-ahead flags and occupancy counts
module synch_fifo_core #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3,
   parameter int CNT_W  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic              rd_en,
   input  logic [DATA_W-1:0] write_data,
   output logic [DATA_W-1:0] read_data,
   output logic              full,
   output logic              empty,
   output logic              full_nxt,
   output logic              empty_nxt,
   output logic [CNT_W-1:0]  room_avail,
   output logic [CNT_W-1:0]  data_avail,
   output logic [DATA_W-1:0] memory_wire
);
   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  count, count_nxt;
   logic              wr_acc, rd_acc;
   // accept decisions and next-state flags from pre-edge state
   always_comb begin
      wr_acc      = wr_en & ~full;
      rd_acc      = rd_en & ~empty;
      count_nxt   = count + CNT_W'(wr_acc) - CNT_W'(rd_acc);
      full_nxt    = count_nxt == CNT_W'(DEPTH);
      empty_nxt   = count_nxt == '0;
      memory_wire = mem[rd_ptr];
   end
   assign data_avail = count;
   // storage, pointers, registered read data and flags; reset wipes everything at once
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         full       <= 1'b0;
         empty      <= 1'b1;
         room_avail <= CNT_W'(DEPTH);
         read_data  <= '0;
      end else begin
         if (wr_acc) begin
            mem[wr_ptr] <= write_data;
            wr_ptr      <= wr_ptr + ADDR_W'(1);
         end
         if (rd_acc) begin
            read_data <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + ADDR_W'(1);
         end
         count      <= count_nxt;
         full       <= full_nxt;
         empty      <= empty_nxt;
         room_avail <= CNT_W'(DEPTH) - count_nxt;
      end
   end
endmodule

// File: tb/tb_synch_fifo_core.sv
// tb_synch_fifo_core: directed self-checking bench for synch_fifo_core
module tb_synch_fifo_core;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        wr_en = 1'b0;
   logic        rd_en = 1'b0;
   logic [15:0] write_data = '0;
   logic [15:0] read_data, memory_wire;
   logic        full, empty, full_nxt, empty_nxt;
   logic [3:0]  room_avail, data_avail;
   int          n_cmp = 0;
   int          n_err = 0;
   logic [15:0] raw_v [8] = '{16'h0012, 16'h00A5, 16'h00FF, 16'h0000, 16'h0081, 16'h007E, 16'h0033, 16'h00C9};

   synch_fifo_core dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .rd_en(rd_en), .write_data(write_data),
      .read_data(read_data), .full(full), .empty(empty), .full_nxt(full_nxt), .empty_nxt(empty_nxt),
      .room_avail(room_avail), .data_avail(data_avail), .memory_wire(memory_wire)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [15:0] d);
      wr_en = 1'b1;
      write_data = d;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic rd();
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_empty"}, 32'(empty), 1);
      chk({tag, "_full"}, 32'(full), 0);
      chk({tag, "_data_avail"}, 32'(data_avail), 0);
      chk({tag, "_room_avail"}, 32'(room_avail), 8);
      chk({tag, "_read_data"}, 32'(read_data), 0);
      chk({tag, "_memory_wire"}, 32'(memory_wire), 0);
   endtask

   initial begin
      #1 reset = 1'b0;
      #49;
      chk_reset("in_reset");
      #50 reset = 1'b1;
      tick();
      chk_reset("post_reset");
      chk("post_reset_empty_nxt", 32'(empty_nxt), 1);
      chk("post_reset_full_nxt", 32'(full_nxt), 0);

      for (int i = 0; i < 8; i++) begin
         wr(raw_v[i]);
         chk("raw_avail", 32'(data_avail), 1);
         chk("raw_head", 32'(memory_wire), 32'(raw_v[i]));
         chk("raw_not_empty", 32'(empty), 0);
         rd();
         chk("raw_read", 32'(read_data), 32'(raw_v[i]));
         chk("raw_empty", 32'(empty), 1);
      end

      for (int i = 0; i < 9; i++) begin
         logic [7:0] b;
         b = ~8'(i + 1);
         wr_en = 1'b1;
         write_data = {8'h00, b};
         if (i == 7) chk("fill_full_nxt", 32'(full_nxt), 1);
         tick();
         wr_en = 1'b0;
         chk("fill_avail", 32'(data_avail), (i < 8) ? i + 1 : 8);
      end
      chk("fill_full", 32'(full), 1);
      chk("fill_room", 32'(room_avail), 0);
      chk("fill_head", 32'(memory_wire), 32'h00FE);

      for (int i = 0; i < 20; i++) begin
         rd_en = 1'b1;
         if (i == 7) chk("drain_empty_nxt", 32'(empty_nxt), 1);
         tick();
         rd_en = 1'b0;
         chk("drain_read", 32'(read_data), (i < 8) ? 32'h00FE - 32'(i) : 32'h00F7);
         if (i == 0) chk("drain_not_full", 32'(full), 0);
         if (i == 7) chk("drain_empty", 32'(empty), 1);
      end
      chk("drain_room", 32'(room_avail), 8);

      wr(16'h1111);
      wr(16'h2222);
      wr(16'h3333);
      wr_en = 1'b1; rd_en = 1'b1; write_data = 16'h4444;
      tick();
      wr_en = 1'b0; rd_en = 1'b0;
      chk("sim3_avail", 32'(data_avail), 3);
      chk("sim3_read", 32'(read_data), 32'h1111);
      for (int k = 0; k < 5; k++) wr(16'h5000 + 16'(k));
      chk("simfull_full", 32'(full), 1);
      wr_en = 1'b1; rd_en = 1'b1; write_data = 16'hAAAA;
      tick();
      wr_en = 1'b0; rd_en = 1'b0;
      chk("simfull_avail", 32'(data_avail), 7);
      chk("simfull_read", 32'(read_data), 32'h2222);
      chk("simfull_full", 32'(full), 0);
      rd();
      chk("simfull_seq0", 32'(read_data), 32'h3333);
      rd();
      chk("simfull_seq1", 32'(read_data), 32'h4444);
      for (int k = 0; k < 5; k++) begin
         rd();
         chk("simfull_seq", 32'(read_data), 32'h5000 + 32'(k));
      end
      chk("simfull_drained", 32'(empty), 1);
      wr_en = 1'b1; rd_en = 1'b1; write_data = 16'hBBBB;
      tick();
      wr_en = 1'b0; rd_en = 1'b0;
      chk("simempty_avail", 32'(data_avail), 1);
      chk("simempty_read_held", 32'(read_data), 32'h5004);
      chk("simempty_head", 32'(memory_wire), 32'hBBBB);
      rd();
      chk("simempty_read", 32'(read_data), 32'hBBBB);

      for (int k = 0; k < 20; k++) begin
         wr(16'hC000 + 16'(k));
         rd();
         chk("wrap_read", 32'(read_data), 32'hC000 + 32'(k));
      end
      chk("wrap_empty", 32'(empty), 1);

      for (int k = 0; k < 5; k++) wr(16'hD000 + 16'(k));
      chk("pre_areset_avail", 32'(data_avail), 5);
      chk("pre_areset_room", 32'(room_avail), 3);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk_reset("async_reset");
      #2 reset = 1'b1;
      tick();
      chk("post_areset_empty", 32'(empty), 1);
      chk("post_areset_avail", 32'(data_avail), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
